// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage following the EX register.
// Issues one word load/store per instruction on the CPU data bus,
// requests a pipeline stall while the bus is busy, flags misaligned
// accesses and registers the MEM outputs for writeback/control.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall, flush    pipeline controller inputs
//   busy            stall request to the pipeline controller
//   ex_*            EX pipeline register outputs (ALU result in ex_data_out)
//   bus_*           CPU data bus (as_/rdy_ active-low, rw 1=read)
//   mem_*           registered MEM pipeline outputs
//
// Optional: define MEM_BUS_TIMEOUT_EN to add a bus watchdog that retires
// a stuck access with BUS_ERR after TIMEOUT busy cycles.
module mem_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [DATA_W-1:0] ex_data_out,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_LDW = 2'd1;
    localparam logic [2:0] EXP_NONE      = 3'd0;
    localparam logic [2:0] EXP_MISALIGN  = 3'd4;
    localparam logic [2:0] EXP_BUS_ERR   = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

    logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_br_flag_q, mem_br_flag_d;
    logic [1:0]        mem_ctrl_op_q, mem_ctrl_op_d;
    logic [4:0]        mem_dst_addr_q, mem_dst_addr_d;
    logic              mem_gpr_we__q, mem_gpr_we__d;
    logic [2:0]        mem_exp_code_q, mem_exp_code_d;
    logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;

    logic              misalign;
    logic              go;
    logic              timed_out;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign misalign = (ex_mem_op != OP_NOP) && (ex_data_out[1:0] != 2'b00);
    assign go       = ex_en && (ex_mem_op != OP_NOP) && (ex_exp_code == EXP_NONE)
                      && !misalign && !flush;

    // Bus address/data always follow the EX inputs; the stall keeps them
    // frozen for the whole access.
    assign bus_rw      = (ex_mem_op == OP_LDW);
    assign bus_addr    = ex_data_out[ADDR_W+1:2];
    assign bus_wr_data = ex_mem_wr_data;

    // A held result comes from rd_buf; otherwise the load completes this
    // cycle and the bus data is taken directly.
    assign load_data = (state_q == ST_DONE) ? rd_buf_q : bus_rd_data;

    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        rd_buf_d  = rd_buf_q;
        bus_as_   = 1'b1;
        busy      = 1'b0;
        timed_out = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    bus_as_ = 1'b0;
                    if (!bus_rdy_) begin
                        rd_buf_d = bus_rd_data;
                        if (stall) state_d = ST_DONE;
                    end else begin
                        busy    = 1'b1;
                        state_d = ST_ACCESS;
`ifdef MEM_BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                bus_as_ = 1'b0;
                if (!bus_rdy_) begin
                    rd_buf_d = bus_rd_data;
                    state_d  = stall ? ST_DONE : ST_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Entry cycle in IDLE counts as the first busy cycle.
                    bus_as_   = 1'b1;
                    timed_out = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    busy  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
`else
                end else begin
                    busy = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (!stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flushed in-flight access still runs to completion on the bus;
        // the sticky flag discards its result when it retires.
        if (state_d == ST_IDLE)
            abort_d = 1'b0;
        else if (flush && (state_q != ST_IDLE))
            abort_d = 1'b1;
    end

    always_comb begin
        mem_pc_d       = mem_pc_q;
        mem_en_d       = mem_en_q;
        mem_br_flag_d  = mem_br_flag_q;
        mem_ctrl_op_d  = mem_ctrl_op_q;
        mem_dst_addr_d = mem_dst_addr_q;
        mem_gpr_we__d  = mem_gpr_we__q;
        mem_exp_code_d = mem_exp_code_q;
        mem_data_out_d = mem_data_out_q;
        if (!stall) begin
            if (flush || abort_q) begin
                mem_pc_d       = '0;
                mem_en_d       = 1'b0;
                mem_br_flag_d  = 1'b0;
                mem_ctrl_op_d  = '0;
                mem_dst_addr_d = '0;
                mem_gpr_we__d  = 1'b1;
                mem_exp_code_d = EXP_NONE;
                mem_data_out_d = '0;
            end else begin
                mem_pc_d       = ex_pc;
                mem_en_d       = ex_en;
                mem_br_flag_d  = ex_br_flag;
                mem_ctrl_op_d  = '0;
                mem_dst_addr_d = '0;
                mem_gpr_we__d  = 1'b1;
                mem_data_out_d = '0;
                if (ex_exp_code != EXP_NONE)
                    mem_exp_code_d = ex_exp_code;
                else if (misalign)
                    mem_exp_code_d = EXP_MISALIGN;
                else if (timed_out)
                    mem_exp_code_d = EXP_BUS_ERR;
                else begin
                    mem_exp_code_d = EXP_NONE;
                    mem_ctrl_op_d  = ex_ctrl_op;
                    mem_dst_addr_d = ex_dst_addr;
                    mem_gpr_we__d  = ex_gpr_we_;
                    mem_data_out_d = (ex_mem_op == OP_LDW) ? load_data : ex_data_out;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            abort_q        <= 1'b0;
            rd_buf_q       <= '0;
            mem_pc_q       <= '0;
            mem_en_q       <= 1'b0;
            mem_br_flag_q  <= 1'b0;
            mem_ctrl_op_q  <= '0;
            mem_dst_addr_q <= '0;
            mem_gpr_we__q  <= 1'b1;
            mem_exp_code_q <= EXP_NONE;
            mem_data_out_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            abort_q        <= abort_d;
            rd_buf_q       <= rd_buf_d;
            mem_pc_q       <= mem_pc_d;
            mem_en_q       <= mem_en_d;
            mem_br_flag_q  <= mem_br_flag_d;
            mem_ctrl_op_q  <= mem_ctrl_op_d;
            mem_dst_addr_q <= mem_dst_addr_d;
            mem_gpr_we__q  <= mem_gpr_we__d;
            mem_exp_code_q <= mem_exp_code_d;
            mem_data_out_q <= mem_data_out_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign mem_pc       = mem_pc_q;
    assign mem_en       = mem_en_q;
    assign mem_br_flag  = mem_br_flag_q;
    assign mem_ctrl_op  = mem_ctrl_op_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_we_  = mem_gpr_we__q;
    assign mem_exp_code = mem_exp_code_q;
    assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed instructions, expected MEM outputs
// queued by the driver and compared by a monitor whenever the pipeline
// advances a valid instruction; bus/busy behaviour checked inline.
module tb_mem_stage;

    localparam logic [1:0] LDW = 2'd1;
    localparam logic [1:0] STW = 2'd2;

    logic        clk = 1'b0;
    logic        rst, ext_stall, stall, flush, busy;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_data_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic        bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_data_out;

    always #5 clk = ~clk;

    // The pipeline controller stalls on busy or an external stall.
    assign stall = busy | ext_stall;

    mem_stage #(
`ifdef MEM_BUS_TIMEOUT_EN
        .TIMEOUT(4),
`endif
        .DATA_W(32),
        .ADDR_W(30)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
        .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
        .ex_data_out(ex_data_out),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_data_out(mem_data_out)
    );

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] data;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    task automatic push(input logic [29:0] pc, input logic en, input logic br,
                        input logic [1:0] ctrl, input logic [4:0] dst, input logic we_,
                        input logic [2:0] ec, input logic [31:0] data);
        out_t e;
        e.pc = pc; e.en = en; e.br = br; e.ctrl = ctrl; e.dst = dst;
        e.we_ = we_; e.exp = ec; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [29:0] pc,
                          input logic [4:0] dst, input logic we_, input logic [1:0] ctrl,
                          input logic br, input logic [2:0] ec);
        ex_en = en; ex_mem_op = op; ex_data_out = addr; ex_mem_wr_data = wdata;
        ex_pc = pc; ex_dst_addr = dst; ex_gpr_we_ = we_; ex_ctrl_op = ctrl;
        ex_br_flag = br; ex_exp_code = ec;
    endtask

    task automatic bubble();
        set_ex(1'b0, 2'd0, 32'h0, 32'h0, 30'h0, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
    endtask

    // Monitor: an instruction leaves the stage at every edge where the
    // pipeline is not stalled and EX holds a valid instruction.
    initial begin
        logic adv;
        out_t e;
        forever begin
            @(negedge clk);
            #2;
            adv = !rst && !stall && ex_en;
            @(posedge clk);
            #1;
            if (adv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb.unexpected: actual=pc 0x%0h required=no output", mem_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb.pc",   32'(mem_pc),       32'(e.pc));
                    chk("sb.en",   32'(mem_en),       32'(e.en));
                    chk("sb.br",   32'(mem_br_flag),  32'(e.br));
                    chk("sb.ctrl", 32'(mem_ctrl_op),  32'(e.ctrl));
                    chk("sb.dst",  32'(mem_dst_addr), 32'(e.dst));
                    chk("sb.we_",  32'(mem_gpr_we_),  32'(e.we_));
                    chk("sb.exp",  32'(mem_exp_code), 32'(e.exp));
                    chk("sb.data", mem_data_out,      e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1);
    end

    initial begin
        int unsigned busy_cnt;
        rst = 1'b1; ext_stall = 1'b0; flush = 1'b0;
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        bubble();
        repeat (3) @(negedge clk);
        #1;
        chk("rst.mem_en",   32'(mem_en), 0);
        chk("rst.mem_we_",  32'(mem_gpr_we_), 1);
        chk("rst.mem_pc",   32'(mem_pc), 0);
        chk("rst.mem_data", mem_data_out, 0);
        chk("rst.mem_ctrl", 32'(mem_ctrl_op), 0);
        chk("rst.busy",     32'(busy), 0);
        chk("rst.bus_as_",  32'(bus_as_), 1);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait load
        set_ex(1'b1, LDW, 32'h0000_1000, 32'h0, 30'h100, 5'd3, 1'b0, 2'd1, 1'b0, 3'd0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        push(30'h100, 1'b1, 1'b0, 2'd1, 5'd3, 1'b0, 3'd0, 32'hDEAD_BEEF);
        #1;
        chk("ldw0.bus_addr", 32'(bus_addr), 32'h400);
        chk("ldw0.busy",     32'(busy), 0);
        chk("ldw0.bus_as_",  32'(bus_as_), 0);
        chk("ldw0.bus_rw",   32'(bus_rw), 1);
        @(negedge clk);
        bubble(); bus_rdy_ = 1'b1; bus_rd_data = '0;
        @(negedge clk);

        // Store with three wait cycles
        set_ex(1'b1, STW, 32'h20, 32'h1234_5678, 30'h101, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
        push(30'h101, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h20);
        busy_cnt = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (c == 3) bus_rdy_ = 1'b0;
            #1;
            if (busy) busy_cnt++;
            chk("stw.bus_rw",   32'(bus_rw), 0);
            chk("stw.bus_wdat", bus_wr_data, 32'h1234_5678);
            chk("stw.bus_addr", 32'(bus_addr), 32'h8);
            chk("stw.bus_as_",  32'(bus_as_), 0);
            @(negedge clk);
        end
        chk("stw.busy_cycles", busy_cnt, 3);
        bubble(); bus_rdy_ = 1'b1;
        @(negedge clk);

        // Misaligned load: no bus access, MISS_ALIGN retired
        set_ex(1'b1, LDW, 32'h1002, 32'h0, 30'h102, 5'd5, 1'b0, 2'd2, 1'b1, 3'd0);
        push(30'h102, 1'b1, 1'b1, 2'd0, 5'd0, 1'b1, 3'd4, 32'h0);
        #1;
        chk("mis.bus_as_", 32'(bus_as_), 1);
        chk("mis.busy",    32'(busy), 0);
        @(negedge clk);

        // Upstream exception passes through without a bus access
        set_ex(1'b1, LDW, 32'h1000, 32'h0, 30'h106, 5'd9, 1'b0, 2'd3, 1'b0, 3'd7);
        push(30'h106, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd7, 32'h0);
        #1;
        chk("exc.bus_as_", 32'(bus_as_), 1);
        @(negedge clk);
        bubble();
        @(negedge clk);

        // Flush in the second ACCESS cycle; access still completes
        set_ex(1'b1, LDW, 32'h2000, 32'h0, 30'h103, 5'd6, 1'b0, 2'd1, 1'b0, 3'd0);
        push(30'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0);
        #1;
        chk("fl.busy_idle", 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl.busy_access", 32'(busy), 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl.bus_as_hold", 32'(bus_as_), 0);
        @(negedge clk);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hBAD0_BAD0;
        #1;
        chk("fl.bus_as_done", 32'(bus_as_), 0);
        chk("fl.busy_done",   32'(busy), 0);
        @(negedge clk);
        set_ex(1'b1, LDW, 32'h3004, 32'h0, 30'h104, 5'd7, 1'b0, 2'd1, 1'b0, 3'd0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
        push(30'h104, 1'b1, 1'b0, 2'd1, 5'd7, 1'b0, 3'd0, 32'hCAFE_F00D);
        #1;
        chk("fl.next_addr", 32'(bus_addr), 32'hC01);
        chk("fl.next_as_",  32'(bus_as_), 0);
        @(negedge clk);
        bubble(); bus_rdy_ = 1'b1; bus_rd_data = '0;
        @(negedge clk);

        // Load completes under external stall; result held in DONE
        set_ex(1'b1, LDW, 32'h44, 32'h0, 30'h105, 5'd8, 1'b0, 2'd1, 1'b0, 3'd0);
        push(30'h105, 1'b1, 1'b0, 2'd1, 5'd8, 1'b0, 3'd0, 32'h5A5A_A5A5);
        @(negedge clk);
        ext_stall = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h5A5A_A5A5;
        @(negedge clk);
        bus_rdy_ = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            chk("hold.bus_as_", 32'(bus_as_), 1);
            chk("hold.busy",    32'(busy), 0);
            @(negedge clk);
        end
        ext_stall = 1'b0;
        #1;
        chk("hold.no_reissue", 32'(bus_as_), 1);
        @(negedge clk);
        bubble();
        @(negedge clk);

`ifdef MEM_BUS_TIMEOUT_EN
        // Bus never answers: watchdog retires BUS_ERR after 4 busy cycles
        set_ex(1'b1, LDW, 32'h80, 32'h0, 30'h107, 5'd10, 1'b0, 2'd1, 1'b0, 3'd0);
        push(30'h107, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd7, 32'h0);
        busy_cnt = 0;
        for (int unsigned c = 0; c < 5; c++) begin
            #1;
            if (busy) busy_cnt++;
            if (c == 4) chk("to.bus_as_", 32'(bus_as_), 1);
            @(negedge clk);
        end
        chk("to.busy_cycles", busy_cnt, 4);
        bubble();
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb.drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX pipeline register.
- Consumes ex_pc/ex_en, the EX control bundle and the ALU result.
- Issues one word load or store per instruction on the CPU data bus and stalls the pipeline while the bus is busy.
- Flags misaligned accesses and registers the MEM pipeline outputs for the writeback/control stage.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 30, word-address width (byte address = ADDR_W+2 bits)
- TIMEOUT, 255, bus watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall from the pipeline controller
- flush  in  1  pipeline flush from the pipeline controller
- busy  out  1  stall request to the pipeline controller
- ex_pc  in  ADDR_W  EX-stage PC
- ex_en  in  1  EX-stage valid
- ex_br_flag  in  1  branch-delay flag
- ex_mem_op  in  2  0=NOP, 1=LDW, 2=STW
- ex_mem_wr_data  in  DATA_W  store data
- ex_ctrl_op  in  2  control op, passed through
- ex_dst_addr  in  5  GPR destination
- ex_gpr_we_  in  1  GPR write enable, active-low
- ex_exp_code  in  3  upstream exception code (0=NO_EXP, 4=MISS_ALIGN, 7=BUS_ERR)
- ex_data_out  in  DATA_W  ALU result; byte address for loads and stores
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1=read, 0=write
- bus_addr  out  ADDR_W  word address = ex_data_out[ADDR_W+1:2]
- bus_wr_data  out  DATA_W  store data
- bus_rd_data  in  DATA_W  load data
- bus_rdy_  in  1  access complete, active-low
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code  out  (as EX inputs)  registered pass-through
- mem_data_out  out  DATA_W  load data or ALU result

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM=IDLE; busy=0; bus_as_=1; abort flag=0.
  - Output register: mem_pc=0, mem_en=0, mem_br_flag=0, mem_ctrl_op=NOP, mem_dst_addr=0, mem_gpr_we_=1, mem_exp_code=0, mem_data_out=0.
  - Reset mid-access drops the transaction; the bus slave is reset by the same rst.
- misalign = ex_mem_op!=NOP && ex_data_out[1:0]!=0.
- go = ex_en && ex_mem_op!=NOP && ex_exp_code==0 && !misalign && !flush.
- FSM:
  - IDLE:
    - When go: bus_as_=0 combinationally; bus_rw/addr/wr_data driven from the EX inputs.
    - If bus_rdy_=0 in the same cycle (zero-wait): capture bus_rd_data into rd_buf and go to DONE if stall=1; otherwise complete in place with busy=0.
    - If bus_rdy_=1: go to ACCESS; busy=1.
  - ACCESS:
    - bus_as_=0; bus signals held (EX inputs are frozen by the stall); busy=1.
    - On bus_rdy_=0: rd_buf<=bus_rd_data; busy=0 that cycle; next state DONE if stall=1, else IDLE.
  - DONE:
    - bus_as_=1; busy=0.
    - Holds rd_buf until stall=0, then returns to IDLE.
    - No new access is issued for the held instruction.
- Busy is combinational: busy = (state==IDLE && go && bus_rdy_) || (state==ACCESS && bus_rdy_).
- Flush while in ACCESS:
  - Sets the sticky abort flag.
  - The access completes on the bus (not cancellable), then the result is discarded.
  - The abort flag clears on return to IDLE.
- Output register updates only when stall=0. Priority:
  1. flush or abort: full reset values.
  2. ex_exp_code!=0: pass pc/en/br_flag/exp_code; result fields reset.
  3. misalign: pass pc/en/br_flag; exp_code=4; result fields reset; no bus access.
  4. Normal: pass all fields; mem_data_out = (mem_op==LDW) ? rd_buf-or-bus_rd_data : ex_data_out.
- With stall=1, the output register holds.
- Store results: mem_gpr_we_ is passed through unchanged (decode disables it).

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider watchdog counter runs in ACCESS.
  - When it reaches TIMEOUT: force IDLE, bus_as_=1, busy=0; the instruction retires with exp_code=7 (BUS_ERR) and result fields reset.
  - The counter clears on every entry to ACCESS.
- Undefined: no counter; ACCESS waits for bus_rdy_ indefinitely.

Test Plan:
- Zero-wait LDW:
  - Stimulus: ex_data_out=0x0000_1000, bus_rdy_=0 in the same cycle, bus_rd_data=0xDEADBEEF, stall=0.
  - Response: bus_addr=0x400, busy never 1, next cycle mem_data_out=0xDEADBEEF.
- 3-wait STW:
  - Stimulus: addr 0x20, wr_data 0x12345678, bus_rdy_ low on the 4th cycle.
  - Response: busy=1 for 3 cycles; bus_rw=0 and bus_wr_data stable throughout; mem_data_out=0x20 after completion.
- Misaligned LDW:
  - Stimulus: ex_data_out=0x1002.
  - Response: bus_as_ stays 1; mem_exp_code=4; mem_gpr_we_=1; mem_data_out=0.
- Flush mid-access:
  - Stimulus: flush=1 in the 2nd cycle of ACCESS; bus_rdy_ arrives 2 cycles later.
  - Response: access completes; outputs at reset values; next LDW proceeds normally.
- Held result:
  - Stimulus: load completes while an external stall=1 holds for 3 cycles.
  - Response: state DONE; bus_as_=1; after stall drops, mem_data_out equals the captured rd_data.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT=4:
  - Stimulus: bus_rdy_ held at 1.
  - Response: busy for 4 cycles; then mem_exp_code=7 and busy=0.
